// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one MAC TX AXI-stream from N_PORTS sources.
// A stall watchdog aborts a frame whose owner stops supplying data mid-frame.
// Optional inter-frame gap state compiled in with `define ETH_TX_ARB_IFG_EN.
module eth_tx_frame_arbiter #(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_STALL  = 16,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS*DATA_W-1:0]   s_tdata,
  input  logic [N_PORTS-1:0]          s_tvalid,
  input  logic [N_PORTS-1:0]          s_tlast,
  output logic [N_PORTS-1:0]          s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  output logic                        m_tuser,
  input  logic                        m_tready,
  output logic [N_PORTS-1:0]          grant,
  output logic                        busy,
  output logic                        abort_pulse
);

  localparam int unsigned PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned STALL_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_XFER  = 3'd1;
  localparam logic [2:0] S_ABORT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef ETH_TX_ARB_IFG_EN
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam int unsigned GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
`endif

  logic [2:0]         state, state_d;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [STALL_W-1:0] stall_cnt, stall_cnt_d;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx;
  logic               found;
  logic               g_valid;
  logic               g_last;
  logic [DATA_W-1:0]  g_data;
  logic [2:0]         end_state;

`ifdef ETH_TX_ARB_IFG_EN
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  assign end_state = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
`else
  logic unused_ifg;
  assign unused_ifg = ^32'(IFG_CYCLES);
  assign end_state  = S_IDLE;
`endif

  // Owner's stream, selected by the pointer (pointer == current winner while busy)
  assign g_valid = s_tvalid[ptr];
  assign g_last  = s_tlast[ptr];
  assign g_data  = s_tdata[32'(ptr) * DATA_W +: DATA_W];

  // Status decoded from the state register
  assign busy  = (state != S_IDLE);
  assign grant = ((state == S_XFER) || (state == S_ABORT) || (state == S_DRAIN))
                 ? (N_PORTS'(1) << ptr) : '0;

  // Round-robin search starting one past the last winner
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_PORTS; i++) begin
      idx = PTR_W'((32'(ptr) + i) % N_PORTS);
      if (!found && s_tvalid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // State, pointer and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= PTR_W'(N_PORTS - 1);
      stall_cnt <= '0;
`ifdef ETH_TX_ARB_IFG_EN
      gap_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      stall_cnt <= stall_cnt_d;
`ifdef ETH_TX_ARB_IFG_EN
      gap_cnt   <= gap_cnt_d;
`endif
    end
  end

  // Next-state logic and stream muxing
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    stall_cnt_d = '0;
`ifdef ETH_TX_ARB_IFG_EN
    gap_cnt_d   = '0;
`endif
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;
    s_tready    = '0;
    abort_pulse = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          ptr_d   = win;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        m_tdata       = g_data;
        m_tvalid      = g_valid;
        m_tlast       = g_last;
        s_tready[ptr] = m_tready;
        if (g_valid) begin
          if (m_tready && g_last) state_d = end_state;
        end else if (MAX_STALL != 0) begin
          // Only source starvation counts; MAC backpressure has g_valid high
          if (stall_cnt == STALL_W'(MAX_STALL - 1)) state_d = S_ABORT;
          else stall_cnt_d = stall_cnt + STALL_W'(1);
        end
      end
      S_ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        if (m_tready) begin
          abort_pulse = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        s_tready[ptr] = 1'b1;
        if (g_valid && g_last) state_d = end_state;
      end
`ifdef ETH_TX_ARB_IFG_EN
      S_GAP: begin
        if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt + GAP_W'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed self-checking bench for eth_tx_frame_arbiter (N_PORTS=2, DATA_W=8, MAX_STALL=16).
module tb_eth_tx_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tlast;
  logic [1:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;
  logic [1:0]  grant;
  logic        busy;
  logic        abort_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  eth_tx_frame_arbiter #(
    .N_PORTS(2), .DATA_W(8), .MAX_STALL(16), .IFG_CYCLES(12)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready), .grant(grant), .busy(busy), .abort_pulse(abort_pulse)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [7:0] d, input logic l);
    s_tvalid[p]      = v;
    s_tdata[p*8 +: 8] = d;
    s_tlast[p]       = l;
  endtask

  task automatic do_reset();
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int beat [2];
    int order [$];
    int both, derr, err, w, gap, ap, o;
    logic [1:0] hs;
    logic [7:0] exp_d;

    // ---- reset state (requests present during reset must be ignored)
    rst_n = 1'b0; s_tvalid = 2'b01; s_tlast = '0; s_tdata = 16'h0012; m_tready = 1'b1;
    tick(); #2;
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_m_tdata", 32'(m_tdata), 0);
    check("rst_m_tlast", 32'(m_tlast), 0);
    check("rst_m_tuser", 32'(m_tuser), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_s_tready", 32'(s_tready), 0);
    check("rst_abort_pulse", 32'(abort_pulse), 0);
    s_tvalid = '0; s_tdata = '0;
    tick();
    rst_n = 1'b1;

    // ---- 1: simple 3-beat frame on port 0
    tick(); set_port(0, 1'b1, 8'h12, 1'b0); #2;
    check("t1_idle_grant", 32'(grant), 0);
    check("t1_idle_valid", 32'(m_tvalid), 0);
    tick(); #2;
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 1);
    check("t1_s_tready", 32'(s_tready), 32'h1);
    check("t1_d0", 32'(m_tdata), 32'h12);
    check("t1_last0", 32'(m_tlast), 0);
    tick(); set_port(0, 1'b1, 8'h35, 1'b0); #2;
    check("t1_d1", 32'(m_tdata), 32'h35);
    tick(); set_port(0, 1'b1, 8'h8A, 1'b1); #2;
    check("t1_d2", 32'(m_tdata), 32'h8A);
    check("t1_last2", 32'(m_tlast), 1);
    tick(); set_port(0, 1'b0, 8'h00, 1'b0); #2;
    check("t1_busy_after", 32'(busy), 0);
    check("t1_grant_after", 32'(grant), 0);

    // ---- 2: round-robin with both ports streaming 2-beat frames
    do_reset();
    beat[0] = 0; beat[1] = 0; both = 0; derr = 0;
    for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
      for (int p = 0; p < 2; p++)
        set_port(p, 1'b1, 8'((p + 1) * 16 + beat[p]), beat[p] == 1);
      #2;
      if (s_tready[0] && s_tready[1]) both++;
      if (m_tvalid && m_tready) begin
        ap = grant[1] ? 1 : 0;
        exp_d = 8'((ap + 1) * 16 + beat[ap]);
        if (m_tdata !== exp_d) derr++;
        if (m_tlast) order.push_back(ap);
      end
      hs = s_tready & s_tvalid;
      tick();
      for (int p = 0; p < 2; p++) if (hs[p]) beat[p] ^= 1;
    end
    check("t2_frames", 32'(order.size()), 4);
    for (int k = 0; k < 4; k++) begin
      o = (k < order.size()) ? order[k] : 99;
      check($sformatf("t2_order%0d", k), 32'(o), 32'(k % 2));
    end
    check("t2_both_ready", 32'(both), 0);
    check("t2_data", 32'(derr), 0);

    // ---- 3: 50 cycles of MAC backpressure mid-frame on port 1
    do_reset();
    set_port(1, 1'b1, 8'h41, 1'b0); #2;
    check("t3_idle_grant", 32'(grant), 0);
    tick(); #2;
    check("t3_grant", 32'(grant), 32'h2);
    check("t3_d0", 32'(m_tdata), 32'h41);
    tick(); set_port(1, 1'b1, 8'h42, 1'b0); m_tready = 1'b0; #2;
    err = 0;
    for (int i = 0; i < 50; i++) begin
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h42 || m_tuser !== 1'b0 ||
          abort_pulse !== 1'b0 || busy !== 1'b1 || s_tready !== 2'b00) err++;
      tick(); #2;
    end
    check("t3_hold", 32'(err), 0);
    m_tready = 1'b1; #1;
    check("t3_ready_back", 32'(s_tready), 32'h2);
    check("t3_d1", 32'(m_tdata), 32'h42);
    tick(); set_port(1, 1'b1, 8'h43, 1'b1); #2;
    check("t3_d2", 32'(m_tdata), 32'h43);
    check("t3_last", 32'(m_tlast), 1);
    check("t3_tuser", 32'(m_tuser), 0);
    tick(); set_port(1, 1'b0, 8'h00, 1'b0); #2;
    check("t3_busy_after", 32'(busy), 0);

    // ---- 4: stall abort on port 0, drain, then port 1 served
    set_port(0, 1'b1, 8'hE8, 1'b0); set_port(1, 1'b1, 8'h51, 1'b1); m_tready = 1'b1; #2;
    tick(); #2;
    check("t4_grant", 32'(grant), 32'h1);
    check("t4_d0", 32'(m_tdata), 32'hE8);
    tick(); set_port(0, 1'b0, 8'h00, 1'b0); #2;
    err = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_tvalid !== 1'b0 || m_tuser !== 1'b0 || busy !== 1'b1 || grant !== 2'b01) err++;
      tick(); #2;
    end
    check("t4_pre_abort", 32'(err), 0);
    m_tready = 1'b0; #1;
    check("t4_ab_tvalid", 32'(m_tvalid), 1);
    check("t4_ab_tuser", 32'(m_tuser), 1);
    check("t4_ab_tlast", 32'(m_tlast), 1);
    check("t4_ab_tdata", 32'(m_tdata), 0);
    check("t4_ab_s_tready", 32'(s_tready), 0);
    check("t4_ab_pulse_held", 32'(abort_pulse), 0);
    tick(); m_tready = 1'b1; #2;
    check("t4_ab_tuser2", 32'(m_tuser), 1);
    check("t4_ab_pulse", 32'(abort_pulse), 1);
    tick(); set_port(0, 1'b1, 8'h3B, 1'b0); #2;
    check("t4_dr_tvalid0", 32'(m_tvalid), 0);
    check("t4_dr_s_tready", 32'(s_tready), 32'h1);
    check("t4_dr_grant", 32'(grant), 32'h1);
    check("t4_dr_pulse", 32'(abort_pulse), 0);
    tick(); set_port(0, 1'b1, 8'h7C, 1'b0); #2;
    check("t4_dr_tvalid1", 32'(m_tvalid), 0);
    tick(); set_port(0, 1'b1, 8'hA5, 1'b1); #2;
    check("t4_dr_tvalid2", 32'(m_tvalid), 0);
    check("t4_dr_ready2", 32'(s_tready), 32'h1);
    tick(); set_port(0, 1'b0, 8'h00, 1'b0); #2;
    check("t4_idle_grant", 32'(grant), 0);
    tick(); #2;
    check("t4_p1_grant", 32'(grant), 32'h2);
    check("t4_p1_data", 32'(m_tdata), 32'h51);
    check("t4_p1_last", 32'(m_tlast), 1);
    tick(); set_port(1, 1'b0, 8'h00, 1'b0); #2;
    check("t4_busy_after", 32'(busy), 0);

    // ---- 5: gap between back-to-back single-beat frames on port 0
    set_port(0, 1'b1, 8'h60, 1'b1); m_tready = 1'b1; #2;
    w = 0;
    while (!m_tvalid && w < 10) begin tick(); #2; w++; end
    check("t5_first", 32'(m_tvalid), 1);
    gap = 0;
    tick(); #2;
    while (!m_tvalid && gap < 100) begin gap++; tick(); #2; end
`ifdef ETH_TX_ARB_IFG_EN
    check("t5_gap", 32'(gap), 13);
`else
    check("t5_gap", 32'(gap), 1);
`endif
    check("t5_data", 32'(m_tdata), 32'h60);
    tick(); set_port(0, 1'b0, 8'h00, 1'b0);
    w = 0; #2;
    while (busy && w < 40) begin tick(); #2; w++; end
    check("t5_idle", 32'(busy), 0);

    // ---- 6: asynchronous reset in the middle of a port 0 frame
    set_port(0, 1'b1, 8'h71, 1'b0); #2;
    tick(); #2;
    check("t6_d0", 32'(m_tdata), 32'h71);
    tick(); set_port(0, 1'b1, 8'h72, 1'b0); #2;
    check("t6_d1", 32'(m_tdata), 32'h72);
    rst_n = 1'b0; #1;
    check("t6_rst_tvalid", 32'(m_tvalid), 0);
    check("t6_rst_grant", 32'(grant), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_s_tready", 32'(s_tready), 0);
    set_port(0, 1'b0, 8'h00, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    set_port(0, 1'b1, 8'h81, 1'b0); set_port(1, 1'b1, 8'h91, 1'b1); #2;
    check("t6_idle_grant", 32'(grant), 0);
    tick(); #2;
    check("t6_grant", 32'(grant), 32'h1);
    check("t6_n0", 32'(m_tdata), 32'h81);
    tick(); set_port(0, 1'b1, 8'h82, 1'b1); #2;
    check("t6_n1", 32'(m_tdata), 32'h82);
    check("t6_n1_last", 32'(m_tlast), 1);
    check("t6_n1_tuser", 32'(m_tuser), 0);
    tick(); set_port(0, 1'b0, 8'h00, 1'b0); #2;
    check("t6_end_grant", 32'(grant), 0);
    set_port(1, 1'b0, 8'h00, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
